// File: rtl/ram_load_arbiter.sv
// ram_load_arbiter
// Shares the Apple-1 main RAM between the 6502 CPU bus and the MiST
// binary-download (ioctl) stream. While a download runs, and for a settle
// period after it (and after system reset), the CPU is held in reset and
// the RAM port belongs to the downloader.
//
// Ports:
//   clk14, reset            clock and synchronous active-high reset
//   cpu_ce/addr/dout/we     CPU bus cycle toward the RAM
//   cpu_din, cpu_reset      read data and reset back to the CPU
//   dl_active/wr/addr/data  ioctl download stream
//   ram_addr/din/we         single-port synchronous RAM write/address side
//   ram_dout                RAM read data (one cycle after the address)
//   loading                 high while a download is being accepted
//   dl_count                bytes written in the current or last download
module ram_load_arbiter #(
  parameter logic [15:0] DL_BASE     = 16'h0000,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk14,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic [7:0]  cpu_din,
  output logic        cpu_reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  output logic        loading,
  output logic [16:0] dl_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [16:0] COUNT_MAX = 17'h10000;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buf_valid_q, buf_valid_d;
  logic [15:0]      buf_addr_q, buf_addr_d;
  logic [7:0]       buf_data_q, buf_data_d;
  logic [16:0]      count_q, count_d;

  logic capture;
  logic drain;

  assign capture = dl_wr & dl_active;
  // The buffered byte owns the RAM port whenever the block is not idle.
  assign drain   = buf_valid_q & (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    count_d     = count_q;

    // Capture has priority so a new strobe in the drain cycle is not lost.
    if (capture) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = dl_addr + DL_BASE;
      buf_data_d  = dl_data;
    end else if (drain) begin
      buf_valid_d = 1'b0;
    end

    if (drain && (count_q != COUNT_MAX)) begin
      count_d = count_q + 17'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (dl_active) begin
          state_d = ST_LOAD;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        // Wait for the last byte to leave the buffer before settling.
        if (!dl_active && !buf_valid_q) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (dl_active) begin
          state_d = ST_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = HOLD_INIT;
      end
    endcase
  end

  always_ff @(posedge clk14) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      cnt_q       <= HOLD_INIT;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      count_q     <= count_d;
    end
  end

  // RAM port mux. A byte pending when reset arrives is discarded, so the
  // download write is suppressed in that cycle.
  always_comb begin
    if (drain) begin
      ram_addr = buf_addr_q;
      ram_din  = buf_data_q;
      ram_we   = ~reset;
    end else if (state_q == ST_IDLE) begin
      ram_addr = cpu_addr;
      ram_din  = cpu_dout;
      ram_we   = cpu_ce & cpu_we;
    end else begin
      ram_addr = cpu_addr;
      ram_din  = cpu_dout;
      ram_we   = 1'b0;
    end
  end

  assign cpu_din   = ram_dout;
  assign cpu_reset = (state_q != ST_IDLE);
  assign loading   = (state_q == ST_LOAD);
  assign dl_count  = count_q;

endmodule

// File: doc/ram_load_arbiter.md
# ram_load_arbiter

Shares the Apple-1 main RAM between the 6502 CPU bus and the MiST binary-download port (data_io ioctl stream), so files can be loaded into memory while the core runs. It holds the CPU in reset for the whole download and for a fixed settle period afterwards, then hands the RAM back. It sits between the apple1 core's RAM port and the single-port synchronous RAM, in the clk14 domain.

## Interface
- `DL_BASE`, default 16'h0000: offset added to `dl_addr`; the sum wraps modulo 2^16.
- `HOLD_CYCLES`, default 16: number of cycles `cpu_reset` stays high after a download ends or after system reset. Must be ≥ 1.
- `clk14`  in  1  system clock, 14.31818 MHz.
- `reset`  in  1  synchronous reset, active-high.
- `cpu_ce`  in  1  CPU bus-cycle strobe, one clk14 pulse per CPU cycle.
- `cpu_addr`  in  16  CPU address.
- `cpu_dout`  in  8  CPU write data.
- `cpu_we`  in  1  CPU write request, qualified by `cpu_ce`.
- `cpu_din`  out  8  read data to the CPU. Equals `ram_dout`.
- `cpu_reset`  out  1  active-high reset for the CPU.
- `dl_active`  in  1  download in progress (ioctl_download).
- `dl_wr`  in  1  one-cycle byte strobe (ioctl_wr).
- `dl_addr`  in  16  byte address within the file.
- `dl_data`  in  8  byte value.
- `ram_addr`  out  16  RAM address.
- `ram_din`  out  8  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_dout`  in  8  RAM read data, available 1 cycle after the address.
- `loading`  out  1  high while the state is LOAD.
- `dl_count`  out  17  number of bytes written in the current or last download. Saturates at 17'h10000.

## Operation
- **State machine:** IDLE, LOAD, HOLD.
  - IDLE → LOAD when `dl_active`=1.
  - LOAD → HOLD when `dl_active`=0 and the pending buffer is empty. The hold counter loads `HOLD_CYCLES`-1.
  - HOLD decrements its counter every cycle. HOLD → IDLE when the counter is 0.
  - HOLD → LOAD if `dl_active`=1.
- **Pending buffer:** one entry, fields {valid, addr, data}.
  - The buffer captures when `dl_wr`=1 and `dl_active`=1, in any state: addr = `dl_addr`+`DL_BASE` (16-bit wrap), data = `dl_data`.
  - A `dl_wr` with `dl_active`=0 is ignored.
  - The buffer drains in the cycle after capture, provided the state is LOAD or HOLD. If the state is IDLE it drains on the first cycle of LOAD.
  - A capture and a drain in the same cycle are legal, so back-to-back `dl_wr` pulses are accepted with no loss.
- **dl_count:**
  - Cleared on the IDLE→LOAD transition. It is not cleared on HOLD→LOAD.
  - Incremented on each drain, saturating at 17'h10000.
- **RAM mux (combinational):**
  - If the buffer is valid and the state is not IDLE: `ram_addr`=buf.addr, `ram_din`=buf.data, `ram_we`=1.
  - Else if the state is IDLE: `ram_addr`=`cpu_addr`, `ram_din`=`cpu_dout`, `ram_we`=`cpu_ce`&`cpu_we`.
  - Otherwise: `ram_addr`=`cpu_addr`, `ram_we`=0.
  - CPU writes are never performed outside IDLE.
- **Outputs:**
  - `cpu_reset` = (state≠IDLE).
  - `loading` = (state==LOAD).

## Timing
- **Reset values** (in the cycle after `reset` is sampled high):
  - state = HOLD, counter = `HOLD_CYCLES`-1, buffer valid = 0.
  - `cpu_reset`=1, `loading`=0, `ram_we`=0, `dl_count`=0.
  - The CPU therefore receives exactly `HOLD_CYCLES` reset cycles after `reset` deasserts.
- **Reset mid-download:** the pending byte is discarded and `dl_count` is cleared. If `dl_active` is still high, the block re-enters LOAD from HOLD.
- **Download write latency:** `dl_wr` at cycle n gives `ram_we`=1 at cycle n+1 when in LOAD.
- **First strobe in the same cycle `dl_active` rises:** captured at n; state is LOAD at n+1; written at n+1.
- **CPU read latency:** `cpu_din` is valid 1 cycle after `cpu_ce`. This is RAM latency only; the arbiter adds none.
- **Release:** with `dl_active` falling at cycle n and the buffer empty, `cpu_reset` stays high through cycle n+`HOLD_CYCLES` and is 0 from n+`HOLD_CYCLES`+1.
- `dl_count` updates 1 cycle after the drain.

## Test plan
- **Reset release:** `reset`=1 for 3 cycles, then 0, with `HOLD_CYCLES`=16 → `cpu_reset` high for exactly 16 cycles after release, then 0; `ram_we`=0 throughout.
- **CPU pass-through in IDLE:** `cpu_ce`=1, `cpu_we`=1, `cpu_addr`=16'h0280, `cpu_dout`=8'h55 → `ram_we`=1, `ram_addr`=16'h0280, `ram_din`=8'h55. A read of 16'h0280 the next cycle returns 8'h55 on `cpu_din`.
- **Back-to-back download:** `DL_BASE`=16'h0280, 4 consecutive `dl_wr` with `dl_addr` 0..3 and data A0..A3 → RAM addresses 0280..0283 hold A0..A3, `dl_count`=4, and no CPU write is performed during LOAD even with `cpu_we`=1.
- **Address wrap:** `DL_BASE`=16'hFFFE, `dl_addr`=3 → write to 16'h0001.
- **Strobe on the `dl_active` rising edge:** `dl_wr` in the same cycle `dl_active` rises → byte written the next cycle, `loading`=1 the next cycle.
- **Reassert during HOLD:** `dl_active` re-asserts at HOLD counter value 5 → state returns to LOAD, `cpu_reset` never drops, `dl_count` continues from its previous value. Separately, `reset` asserted mid-LOAD with a pending byte → the byte is never written and `dl_count`=0.
